// File: rtl/time_set_entry.sv
// ---------------------------------------------------------------------------
// time_set_entry
//
// Keypad-side writer for the alarm clock counter's load interface. The user
// types four BCD digits in HH:MM order. A set-time command then commits them.
// A successful commit raises load_new_c for exactly one cycle. During that
// cycle the digit outputs hold the new time steady. An abandoned entry is
// cleared after TIMEOUT_SEC one_second ticks with no digit typed.
//
// Configuration macro:
//   TIME_RANGE_CHECK_EN : when defined, a commit of an out-of-range time
//                         (hours > 23 or tens-of-minutes > 5) is rejected.
//                         When undefined, any commit with four digits loads.
//
// Parameters:
//   TIMEOUT_SEC : one_second ticks without a key before ENTRY is abandoned
//                 (2..255)
//
// Ports:
//   clk                      system clock
//   reset                    asynchronous, active-high reset
//   one_second               one-cycle tick, once per second
//   key_valid                one-cycle strobe qualifying key
//   key[3:0]                 key code, 0-9 digits, 10-15 ignored
//   set_time                 one-cycle commit request
//   cancel                   one-cycle abort request
//   new_current_time_*[3:0]  registered HH:MM digits presented to the counter
//   load_new_c               one-cycle load strobe to the counter
//   entry_active             high while an entry is in progress
//   entry_error              one-cycle pulse on a rejected commit
//   entry_timeout            one-cycle pulse when an entry is abandoned
//   digit_count[2:0]         digits captured so far, saturating at 4
// ---------------------------------------------------------------------------
module time_set_entry #(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic       key_valid,
    input  logic [3:0] key,
    input  logic       set_time,
    input  logic       cancel,
    output logic [3:0] new_current_time_ms_hr,
    output logic [3:0] new_current_time_ls_hr,
    output logic [3:0] new_current_time_ms_min,
    output logic [3:0] new_current_time_ls_min,
    output logic       load_new_c,
    output logic       entry_active,
    output logic       entry_error,
    output logic       entry_timeout,
    output logic [2:0] digit_count
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_SEC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        LOAD  = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [7:0] timeout_cnt;
    logic [7:0] timeout_cnt_next;
    logic [7:0] timeout_cnt_inc;

    logic [3:0] ms_hr_next;
    logic [3:0] ls_hr_next;
    logic [3:0] ms_min_next;
    logic [3:0] ls_min_next;
    logic [2:0] count_next;

    logic       load_next;
    logic       active_next;
    logic       error_next;
    logic       timeout_next;

    logic       digit_key;
    logic       time_ok;
    logic       tick_expired;
    logic       do_shift;
    logic       do_clear;

    assign digit_key       = key_valid && (key <= 4'd9);
    assign timeout_cnt_inc = timeout_cnt + 8'd1;
    assign tick_expired    = one_second && (timeout_cnt_inc == TIMEOUT_LIMIT);

    // The range check looks at the digits already captured. It does not look
    // at a key arriving in the same cycle as set_time, because that key is
    // dropped.
`ifdef TIME_RANGE_CHECK_EN
    always_comb begin
        time_ok = (new_current_time_ms_hr <= 4'd2)
               && ((new_current_time_ms_hr == 4'd2) ? (new_current_time_ls_hr <= 4'd3)
                                                    : (new_current_time_ls_hr <= 4'd9))
               && (new_current_time_ms_min <= 4'd5)
               && (new_current_time_ls_min <= 4'd9);
    end
`else
    assign time_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the next values of every registered output.
    // Inside ENTRY the if/else order sets the exit priority:
    // cancel, then set_time, then timeout, then a digit key.
    // Any return to IDLE clears the digits and the count. So does the exit
    // from the single-cycle LOAD state, which means the counter sees the
    // new time for exactly the cycle in which load_new_c is high.
    always_comb begin
        state_next       = state;
        timeout_cnt_next = timeout_cnt;
        count_next       = digit_count;
        error_next       = 1'b0;
        timeout_next     = 1'b0;
        do_shift         = 1'b0;
        do_clear         = 1'b0;

        case (state)
            IDLE: begin
                timeout_cnt_next = 8'd0;
                if (digit_key) begin
                    state_next = ENTRY;
                    do_shift   = 1'b1;
                    count_next = 3'd1;
                end
            end

            ENTRY: begin
                if (cancel) begin
                    state_next       = IDLE;
                    do_clear         = 1'b1;
                    timeout_cnt_next = 8'd0;
                end else if (set_time) begin
                    timeout_cnt_next = 8'd0;
                    if ((digit_count == 3'd4) && time_ok) begin
                        state_next = LOAD;
                    end else begin
                        state_next = ERROR;
                        error_next = 1'b1;
                    end
                end else if (tick_expired) begin
                    state_next       = IDLE;
                    do_clear         = 1'b1;
                    timeout_next     = 1'b1;
                    timeout_cnt_next = 8'd0;
                end else begin
                    if (one_second) begin
                        timeout_cnt_next = timeout_cnt_inc;
                    end
                    if (digit_key) begin
                        do_shift         = 1'b1;
                        timeout_cnt_next = 8'd0;
                        if (digit_count != 3'd4) begin
                            count_next = digit_count + 3'd1;
                        end
                    end
                end
            end

            LOAD: begin
                state_next       = IDLE;
                do_clear         = 1'b1;
                timeout_cnt_next = 8'd0;
            end

            ERROR: begin
                state_next       = IDLE;
                do_clear         = 1'b1;
                timeout_cnt_next = 8'd0;
            end

            default: begin
                state_next       = IDLE;
                do_clear         = 1'b1;
                timeout_cnt_next = 8'd0;
            end
        endcase

        ms_hr_next  = new_current_time_ms_hr;
        ls_hr_next  = new_current_time_ls_hr;
        ms_min_next = new_current_time_ms_min;
        ls_min_next = new_current_time_ls_min;
        if (do_clear) begin
            ms_hr_next  = 4'd0;
            ls_hr_next  = 4'd0;
            ms_min_next = 4'd0;
            ls_min_next = 4'd0;
            count_next  = 3'd0;
        end else if (do_shift) begin
            ms_hr_next  = new_current_time_ls_hr;
            ls_hr_next  = new_current_time_ms_min;
            ms_min_next = new_current_time_ls_min;
            ls_min_next = key;
        end

        load_next   = (state_next == LOAD);
        active_next = (state_next == ENTRY);
    end

    // The digits, the count, the timeout counter and the status flags are
    // all registered. The flags are loaded from the next-state decode, so
    // each one is high in exactly the cycle its state or event applies to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            new_current_time_ms_hr  <= 4'd0;
            new_current_time_ls_hr  <= 4'd0;
            new_current_time_ms_min <= 4'd0;
            new_current_time_ls_min <= 4'd0;
            digit_count             <= 3'd0;
            timeout_cnt             <= 8'd0;
            load_new_c              <= 1'b0;
            entry_active            <= 1'b0;
            entry_error             <= 1'b0;
            entry_timeout           <= 1'b0;
        end else begin
            new_current_time_ms_hr  <= ms_hr_next;
            new_current_time_ls_hr  <= ls_hr_next;
            new_current_time_ms_min <= ms_min_next;
            new_current_time_ls_min <= ls_min_next;
            digit_count             <= count_next;
            timeout_cnt             <= timeout_cnt_next;
            load_new_c              <= load_next;
            entry_active            <= active_next;
            entry_error             <= error_next;
            entry_timeout           <= timeout_next;
        end
    end

endmodule

// File: tb/tb_time_set_entry.sv
// ---------------------------------------------------------------------------
// tb_time_set_entry
//
// Directed bench for time_set_entry. The stimulus process drives inputs on
// the falling clock edge. Each time it issues a command that should produce
// a load, error or timeout pulse, it pushes that expected event into a
// queue. A separate monitor samples on the falling edge. It pops and
// compares whenever the design raises one of those pulses. A pulse with no
// queued expectation counts as a miscompare.
// ---------------------------------------------------------------------------
module tb_time_set_entry;

    localparam logic [1:0] KIND_LOAD    = 2'd0;
    localparam logic [1:0] KIND_ERROR   = 2'd1;
    localparam logic [1:0] KIND_TIMEOUT = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] digits;
    } sb_entry_t;

    logic       clk;
    logic       reset;
    logic       one_second;
    logic       key_valid;
    logic [3:0] key;
    logic       set_time;
    logic       cancel;
    logic [3:0] new_current_time_ms_hr;
    logic [3:0] new_current_time_ls_hr;
    logic [3:0] new_current_time_ms_min;
    logic [3:0] new_current_time_ls_min;
    logic       load_new_c;
    logic       entry_active;
    logic       entry_error;
    logic       entry_timeout;
    logic [2:0] digit_count;
    logic [15:0] shown;

    int vectors;
    int miscompares;
    sb_entry_t sb[$];

    time_set_entry #(.TIMEOUT_SEC(10)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .one_second              (one_second),
        .key_valid               (key_valid),
        .key                     (key),
        .set_time                (set_time),
        .cancel                  (cancel),
        .new_current_time_ms_hr  (new_current_time_ms_hr),
        .new_current_time_ls_hr  (new_current_time_ls_hr),
        .new_current_time_ms_min (new_current_time_ms_min),
        .new_current_time_ls_min (new_current_time_ls_min),
        .load_new_c              (load_new_c),
        .entry_active            (entry_active),
        .entry_error             (entry_error),
        .entry_timeout           (entry_timeout),
        .digit_count             (digit_count)
    );

    assign shown = {new_current_time_ms_hr, new_current_time_ls_hr,
                    new_current_time_ms_min, new_current_time_ls_min};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value against its expected value and keep the counts.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs from the falling edge. When this returns,
    // the outputs still show the effect of the previous vector.
    task automatic applyStimulus(input logic kv, input logic [3:0] k,
                                 input logic st, input logic cn, input logic tick);
        @(negedge clk);
        key_valid  = kv;
        key        = k;
        set_time   = st;
        cancel     = cn;
        one_second = tick;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Type four digits, most significant first.
    task automatic typeDigits(input logic [15:0] d);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b1, d[i*4 +: 4], 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic expectEvent(input logic [1:0] kind, input logic [15:0] digits);
        sb_entry_t e;
        e.kind   = kind;
        e.digits = digits;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation for every load, error or timeout pulse.
    // It also checks that load_new_c never stays high for two cycles.
    initial begin : monitor
        sb_entry_t  e;
        logic [1:0] got_kind;
        logic       prev_load;
        prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_load = 1'b0;
            end else begin
                if (prev_load) begin
                    checkOutput("load_single_cycle", {15'd0, load_new_c}, 16'd0);
                end
                if (load_new_c || entry_error || entry_timeout) begin
                    got_kind = load_new_c ? KIND_LOAD : (entry_error ? KIND_ERROR : KIND_TIMEOUT);
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_event",
                                    {13'd0, load_new_c, entry_error, entry_timeout}, 16'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("event_kind", {14'd0, got_kind}, {14'd0, e.kind});
                        if (e.kind == KIND_LOAD) begin
                            checkOutput("load_digits", shown, e.digits);
                            checkOutput("load_count", {13'd0, digit_count}, 16'd4);
                        end else if (e.kind == KIND_TIMEOUT) begin
                            checkOutput("timeout_digits", shown, 16'h0000);
                            checkOutput("timeout_active", {15'd0, entry_active}, 16'd0);
                        end
                    end
                end
                prev_load = load_new_c;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [15:0] tbl_digits [6];
        logic        tbl_valid  [6];

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        key_valid   = 1'b0;
        key         = 4'd0;
        set_time    = 1'b0;
        cancel      = 1'b0;
        one_second  = 1'b0;

        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_digits",   shown, 16'h0000);
        checkOutput("rst_count",    {13'd0, digit_count}, 16'd0);
        checkOutput("rst_load",     {15'd0, load_new_c}, 16'd0);
        checkOutput("rst_active",   {15'd0, entry_active}, 16'd0);
        checkOutput("rst_error",    {15'd0, entry_error}, 16'd0);
        checkOutput("rst_timeout",  {15'd0, entry_timeout}, 16'd0);
        reset = 1'b0;

        $display("[TB] test 1: load 12:34");
        typeDigits(16'h1234);
        expectEvent(KIND_LOAD, 16'h1234);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1_count", {13'd0, digit_count}, 16'd4);
        checkOutput("t1_active", {15'd0, entry_active}, 16'd1);
        idleCycle();
        idleCycle();
        checkOutput("t1_cleared", shown, 16'h0000);
        checkOutput("t1_count_cleared", {13'd0, digit_count}, 16'd0);

        $display("[TB] test 2: 24:00");
        typeDigits(16'h2400);
`ifdef TIME_RANGE_CHECK_EN
        expectEvent(KIND_ERROR, 16'h0000);
`else
        expectEvent(KIND_LOAD, 16'h2400);
`endif
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t2_cleared", shown, 16'h0000);

        $display("[TB] test 3: short commit");
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        expectEvent(KIND_ERROR, 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t3_count_before", {13'd0, digit_count}, 16'd2);
        idleCycle();
        idleCycle();
        checkOutput("t3_count_after", {13'd0, digit_count}, 16'd0);
        checkOutput("t3_active", {15'd0, entry_active}, 16'd0);

        $display("[TB] test 4: five digits, oldest dropped");
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        typeDigits(16'h1230);
        expectEvent(KIND_LOAD, 16'h1230);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        checkOutput("t4_digits", shown, 16'h1230);
        checkOutput("t4_count", {13'd0, digit_count}, 16'd4);
        idleCycle();
        idleCycle();

        $display("[TB] test 5: timeout");
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            idleCycle();
        end
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
        idleCycle();
        checkOutput("t5_restart_count", {13'd0, digit_count}, 16'd2);
        checkOutput("t5_restart_active", {15'd0, entry_active}, 16'd1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            idleCycle();
        end
        checkOutput("t5_tick9_active", {15'd0, entry_active}, 16'd1);
        checkOutput("t5_tick9_digits", shown, 16'h0053);
        expectEvent(KIND_TIMEOUT, 16'h0000);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        idleCycle();
        checkOutput("t5_timeout_count", {13'd0, digit_count}, 16'd0);
        idleCycle();

        $display("[TB] ignored keys and commands");
        applyStimulus(1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        idleCycle();
        checkOutput("idle_nondigit_active", {15'd0, entry_active}, 16'd0);
        checkOutput("idle_nondigit_count", {13'd0, digit_count}, 16'd0);
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("entry_nondigit_count", {13'd0, digit_count}, 16'd1);
        checkOutput("entry_nondigit_digits", shown, 16'h0007);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("cancel_active", {15'd0, entry_active}, 16'd0);

        $display("[TB] test 6: simultaneous key with set_time / cancel");
        typeDigits(16'h0845);
        expectEvent(KIND_LOAD, 16'h0845);
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
        idleCycle();
        idleCycle();
        checkOutput("t6a_cleared", shown, 16'h0000);
        typeDigits(16'h0845);
        applyStimulus(1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
        idleCycle();
        checkOutput("t6b_digits", shown, 16'h0000);
        checkOutput("t6b_count", {13'd0, digit_count}, 16'd0);
        checkOutput("t6b_active", {15'd0, entry_active}, 16'd0);
        idleCycle();

        $display("[TB] range boundaries");
        tbl_digits[0] = 16'h2359; tbl_valid[0] = 1'b1;
        tbl_digits[1] = 16'h3000; tbl_valid[1] = 1'b0;
        tbl_digits[2] = 16'h1960; tbl_valid[2] = 1'b0;
        tbl_digits[3] = 16'h0000; tbl_valid[3] = 1'b1;
        tbl_digits[4] = 16'h1959; tbl_valid[4] = 1'b1;
        tbl_digits[5] = 16'h2400; tbl_valid[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            typeDigits(tbl_digits[i]);
`ifdef TIME_RANGE_CHECK_EN
            if (tbl_valid[i]) expectEvent(KIND_LOAD, tbl_digits[i]);
            else              expectEvent(KIND_ERROR, 16'h0000);
`else
            expectEvent(KIND_LOAD, tbl_digits[i]);
`endif
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            idleCycle();
            idleCycle();
        end

        $display("[TB] reset mid-entry");
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        idleCycle();
        reset = 1'b1;
        #1;
        checkOutput("midrst_digits", shown, 16'h0000);
        checkOutput("midrst_count", {13'd0, digit_count}, 16'd0);
        checkOutput("midrst_active", {15'd0, entry_active}, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        repeat (5) idleCycle();
        checkOutput("sb_drained", 16'(sb.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/time_set_entry.md
Name: time_set_entry

Overview:
Keypad-side writer for the alarm clock counter's load interface. Collects four BCD digits typed by the user (HH:MM order) and validates them on a set-time command. A valid entry produces a one-cycle load_new_c pulse with the new_current_time digits held stable. Sits between the keypad scanner/debouncer and the counter; the timeout is paced by the one_second tick from the time generator.

Parameters:
TIMEOUT_SEC, 10, one_second ticks without a key in ENTRY before the entry is abandoned; legal range 2..255.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
one_second  input  1  one-cycle tick, once per second
key_valid  input  1  one-cycle strobe: key holds a new keypress
key  input  4  key code; 0-9 are digits, 10-15 are ignored
set_time  input  1  one-cycle commit request
cancel  input  1  one-cycle abort request
new_current_time_ms_hr  output  4  registered tens-of-hours digit
new_current_time_ls_hr  output  4  registered units-of-hours digit
new_current_time_ms_min  output  4  registered tens-of-minutes digit
new_current_time_ls_min  output  4  registered units-of-minutes digit
load_new_c  output  1  one-cycle load strobe to the counter
entry_active  output  1  high while in ENTRY
entry_error  output  1  one-cycle pulse on a rejected commit
entry_timeout  output  1  one-cycle pulse on timeout abandonment
digit_count  output  3  digits captured, 0..4, saturating

Behaviour:
- Reset:
  - all four digit outputs 0
  - load_new_c, entry_active, entry_error, entry_timeout all 0
  - digit_count 0, timeout counter 0, state IDLE
- All outputs are registered; there are no combinational input-to-output paths.
- Digit shift, on an accepted digit: ms_hr<=ls_hr, ls_hr<=ms_min, ms_min<=ls_min, ls_min<=key.
  - The oldest digit is lost.
  - digit_count increments and saturates at 4.
- Non-digit keys (10-15) are ignored in every state.
- The timeout counter clears on every accepted digit and increments on each one_second tick while in ENTRY.
- FSM states:
  - IDLE: digit key -> ENTRY, shift it in, digit_count=1. set_time and cancel are ignored.
  - ENTRY: entry_active=1. Exit priority, highest first:
    - cancel -> IDLE, clear digits and count.
    - set_time with digit_count==4 and time valid -> LOAD.
    - set_time otherwise -> ERROR.
    - Timeout counter reaches TIMEOUT_SEC on a tick -> IDLE, clear digits and count, entry_timeout=1 for one cycle.
    - Digit key -> shift.
    - A simultaneous key_valid loses to cancel and to set_time.
  - LOAD:
    - Lasts exactly one cycle; load_new_c=1 and the digit outputs are unchanged. The counter samples them at the edge ending this cycle.
    - Keys, set_time and cancel are ignored.
    - Then -> IDLE, with digits and count cleared on entry to IDLE.
  - ERROR: one cycle, entry_error=1. Inputs are ignored. Then -> IDLE, with digits and count cleared.
- Latency: set_time sampled at edge N -> load_new_c high from edge N to edge N+1.
- Time valid means all of:
  - ms_hr<=2
  - ls_hr<=9, or ls_hr<=3 when ms_hr==2
  - ms_min<=5
  - ls_min<=9
- Reset mid-entry or mid-LOAD returns to reset values immediately; no load pulse is produced.
- load_new_c is never asserted for more than one consecutive cycle.

Optional Feature:
- Macro: TIME_RANGE_CHECK_EN.
- Defined: the time-valid check applies; an out-of-range commit goes to ERROR.
- Undefined: the check is omitted and any 4-digit commit goes to LOAD. Only digit_count<4 leads to ERROR.
- digit_count handling and the ports are identical in both builds.

Test Plan:
1. Reset, keys 1,2,3,4, set_time -> in the cycle after set_time, load_new_c=1 with outputs 1,2,3,4. Next cycle all outputs 0, digit_count=0.
2. Keys 2,4,0,0, set_time -> with TIME_RANGE_CHECK_EN: entry_error pulse, no load_new_c, outputs 0. Without it: load with 2,4,0,0.
3. Keys 1,2, set_time -> entry_error pulse, digit_count returns to 0, load_new_c stays 0.
4. Keys 9,1,2,3,0 -> digit_count=4, outputs 1,2,3,0; then set_time -> load with 1,2,3,0.
5. Key 5, then 10 one_second ticks without keys -> entry_timeout pulse on the 10th tick, state IDLE, entry_active=0. A key 3 at tick 9 restarts the count instead.
6. Keys 0,8,4,5 with set_time and key_valid in the same cycle -> load 0,8,4,5 and the key is dropped. Repeat with cancel asserted as well -> no load, outputs cleared.
